// File: rtl/pi_actuator_if.sv
// Controller-to-actuator bundle: PI output and mode controls in, slew-limited
// command plus anti-windup and status back out.
interface pi_actuator_if;
    logic signed [31:0] i_PI;
    logic               i_EN;
    logic               i_HOLD;
    logic signed [31:0] o_CMD;
    logic signed [31:0] o_aw;
    logic               o_valid;
    logic               o_sat;

    modport master (
        output i_PI, i_EN, i_HOLD,
        input  o_CMD, o_aw, o_valid, o_sat
    );

    modport slave (
        input  i_PI, i_EN, i_HOLD,
        output o_CMD, o_aw, o_valid, o_sat
    );
endinterface

// File: rtl/pi_actuator.sv
// Plant-side PI actuator: clamps the controller output, slew-limits it into a
// registered command on a prescaled tick and returns the anti-windup term.
// Optional ACT_DEADBAND_EN: TRACK ticks closer than DB to target are skipped.
module pi_actuator #(
    parameter logic signed [31:0] U_MAX = 32'sd100000,
    parameter logic signed [31:0] U_MIN = -32'sd100000,
    parameter int                 STEP  = 1000,
    parameter int                 DIV   = 100,
    parameter int                 DB    = 16
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    pi_actuator_if.slave bus
);

    localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam logic signed [32:0] STEP33   = 33'(STEP);
    localparam logic signed [32:0] AW_HI    = 33'sd2147483647;
    localparam logic signed [32:0] AW_LO    = -33'sd2147483648;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, RAMPDOWN} state_t;

    function automatic logic signed [32:0] ext33(input logic signed [31:0] v);
        logic signed [32:0] r;
        r = {v[31], v};
        return r;
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [32:0] v);
        logic signed [31:0] r;
        if (v > AW_HI)
            r = AW_HI[31:0];
        else if (v < AW_LO)
            r = AW_LO[31:0];
        else
            r = v[31:0];
        return r;
    endfunction

    // One slew step; operands stay in range, so the 33-bit result never wraps.
    function automatic logic signed [31:0] slew(input logic signed [31:0] cur,
                                                 input logic signed [31:0] tgt);
        logic signed [32:0] d;
        logic signed [32:0] n;
        d = ext33(tgt) - ext33(cur);
        if (d > STEP33)
            n = ext33(cur) + STEP33;
        else if (d < -STEP33)
            n = ext33(cur) - STEP33;
        else
            n = ext33(tgt);
        return n[31:0];
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic signed [31:0] r_cmd;
    logic signed [31:0] r_aw_p1;
    logic               r_sat_p1;
    logic               r_valid;

    logic               w_tick;
    logic               w_sat;
    logic               w_db_skip;
    logic signed [31:0] w_u_sat;
    logic signed [31:0] w_aw;
    logic signed [31:0] w_trk_next;
    logic signed [31:0] w_rd_next;

    always_comb begin
        w_u_sat = bus.i_PI;
        w_sat   = 1'b0;
        if (bus.i_PI > U_MAX) begin
            w_u_sat = U_MAX;
            w_sat   = 1'b1;
        end else if (bus.i_PI < U_MIN) begin
            w_u_sat = U_MIN;
            w_sat   = 1'b1;
        end
    end

    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_aw       = sat32(ext33(w_u_sat) - ext33(bus.i_PI));
    assign w_trk_next = slew(r_cmd, w_u_sat);
    assign w_rd_next  = slew(r_cmd, 32'sd0);

`ifdef ACT_DEADBAND_EN
    localparam logic signed [32:0] DB33 = 33'(DB);
    logic signed [32:0] w_db_delta;
    assign w_db_delta = ext33(w_u_sat) - ext33(r_cmd);
    assign w_db_skip  = (w_db_delta < DB33) && (w_db_delta > -DB33);
`else
    // Deadband off: DB is a don't-care and a legal DB is never negative.
    assign w_db_skip = (DB < 0);
`endif

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_aw_p1  <= '0;
            r_sat_p1 <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_cnt    <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_sat_p1 <= w_sat;
            r_aw_p1  <= (r_state == IDLE) ? '0 : w_aw;
            r_valid  <= 1'b0;
            // Updates use the state at this edge; the transition lands on the same edge.
            case (r_state)
                IDLE: begin
                    r_cmd <= '0;
                    if (bus.i_EN)
                        r_state <= TRACK;
                end
                TRACK: begin
                    if (w_tick && !w_db_skip) begin
                        r_cmd   <= w_trk_next;
                        r_valid <= 1'b1;
                    end
                    if (!bus.i_EN)
                        r_state <= RAMPDOWN;
                    else if (bus.i_HOLD)
                        r_state <= HOLD;
                end
                HOLD: begin
                    if (!bus.i_EN)
                        r_state <= RAMPDOWN;
                    else if (!bus.i_HOLD)
                        r_state <= TRACK;
                end
                RAMPDOWN: begin
                    if (w_tick) begin
                        r_cmd   <= w_rd_next;
                        r_valid <= 1'b1;
                    end
                    if (bus.i_EN)
                        r_state <= TRACK;
                    else if (w_tick && (w_rd_next == '0))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_CMD   = r_cmd;
    assign bus.o_aw    = r_aw_p1;
    assign bus.o_valid = r_valid;
    assign bus.o_sat   = r_sat_p1;

endmodule

// File: tb/tb_pi_actuator.sv
// Bench for pi_actuator: table of input phases with end-of-phase expectations,
// a queue of expected command updates consumed on each o_valid, and reset cases.
module tb_pi_actuator;

    logic clk = 1'b0;
    logic rst;

    pi_actuator_if bus();

    pi_actuator #(
        .U_MAX (32'sd1000),
        .U_MIN (-32'sd1000),
        .STEP  (100),
        .DIV   (4),
        .DB    (16)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pi;
        bit en;
        bit hold;
        int ncyc;
        int tgt;
        int nupd;
        int exp_cmd;
        int exp_aw1;
        bit exp_sat1;
        int exp_aw;
        bit exp_sat;
    } vec_t;

    vec_t vecs[12];
    int   q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_cmd  = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic int step_to(int cur, int tgt);
        if (tgt - cur > 100)
            return cur + 100;
        else if (cur - tgt > 100)
            return cur - 100;
        else
            return tgt;
    endfunction

    function automatic void push_ramp(int tgt, int n);
        for (int i = 0; i < n; i++) begin
            m_cmd = step_to(m_cmd, tgt);
            q.push_back(m_cmd);
        end
    endfunction

    // Every o_valid must match the next expected command update.
    always @(posedge clk) begin
        #1;
        if (bus.o_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: o_valid=1 o_CMD=%0d, expected no update", bus.o_CMD);
            end else begin
                chk("valid_cmd", bus.o_CMD, q.pop_front());
            end
        end
    end

    initial begin
        //          pi     en    hold  ncyc tgt    nupd cmd    aw1   sat1  aw    sat
        vecs[0]  = '{500,   1'b0, 1'b0, 40, 0,     0,   0,     0,    1'b0, 0,    1'b0};
        vecs[1]  = '{350,   1'b1, 1'b0, 24, 350,   6,   350,   0,    1'b0, 0,    1'b0};
        vecs[2]  = '{1500,  1'b1, 1'b0, 36, 1000,  9,   1000,  -500, 1'b1, -500, 1'b1};
        vecs[3]  = '{-1200, 1'b1, 1'b0, 84, -1000, 21,  -1000, 200,  1'b1, 200,  1'b1};
        vecs[4]  = '{200,   1'b1, 1'b0, 48, 200,   12,  200,   0,    1'b0, 0,    1'b0};
        vecs[5]  = '{1500,  1'b1, 1'b1, 20, 0,     0,   200,   -500, 1'b1, -500, 1'b1};
        vecs[6]  = '{1500,  1'b1, 1'b0, 4,  1000,  1,   300,   -500, 1'b1, -500, 1'b1};
        vecs[7]  = '{1000,  1'b1, 1'b0, 28, 1000,  7,   1000,  0,    1'b0, 0,    1'b0};
        vecs[8]  = '{1000,  1'b0, 1'b0, 20, 0,     5,   500,   0,    1'b0, 0,    1'b0};
        vecs[9]  = '{1000,  1'b1, 1'b0, 20, 1000,  5,   1000,  0,    1'b0, 0,    1'b0};
        vecs[10] = '{1500,  1'b0, 1'b0, 44, 0,     10,  0,     -500, 1'b1, 0,    1'b1};
        vecs[11] = '{500,   1'b0, 1'b0, 8,  0,     0,   0,     0,    1'b0, 0,    1'b0};

        bus.i_PI   = 0;
        bus.i_EN   = 1'b0;
        bus.i_HOLD = 1'b0;
        rst        = 1'b0;
        #1 rst     = 1'b1;
        @(posedge clk); #2;
        chk("reset_cmd",   bus.o_CMD, 0);
        chk("reset_aw",    bus.o_aw, 0);
        chk("reset_valid", int'(bus.o_valid), 0);
        chk("reset_sat",   int'(bus.o_sat), 0);
        rst = 1'b0;

        for (int r = 0; r < 12; r++) begin
            bus.i_PI   = vecs[r].pi;
            bus.i_EN   = vecs[r].en;
            bus.i_HOLD = vecs[r].hold;
            push_ramp(vecs[r].tgt, vecs[r].nupd);
            for (int c = 1; c <= vecs[r].ncyc; c++) begin
                @(posedge clk); #2;
                if (c == 1) begin
                    chk($sformatf("row%0d_aw_first", r), bus.o_aw, vecs[r].exp_aw1);
                    chk($sformatf("row%0d_sat_first", r), int'(bus.o_sat), int'(vecs[r].exp_sat1));
                end
            end
            chk($sformatf("row%0d_cmd", r), bus.o_CMD, vecs[r].exp_cmd);
            chk($sformatf("row%0d_aw", r), bus.o_aw, vecs[r].exp_aw);
            chk($sformatf("row%0d_sat", r), int'(bus.o_sat), int'(vecs[r].exp_sat));
            chk($sformatf("row%0d_pending_updates", r), q.size(), 0);
        end

        // Asynchronous reset in the middle of a ramp, off the prescaler's phase.
        bus.i_PI   = 1500;
        bus.i_EN   = 1'b1;
        bus.i_HOLD = 1'b0;
        push_ramp(1000, 2);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #2;
        end
        chk("pre_reset_cmd", bus.o_CMD, 200);
        chk("pre_reset_sat", int'(bus.o_sat), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_cmd",   bus.o_CMD, 0);
        chk("async_reset_aw",    bus.o_aw, 0);
        chk("async_reset_valid", int'(bus.o_valid), 0);
        chk("async_reset_sat",   int'(bus.o_sat), 0);
        #2 rst = 1'b0;
        m_cmd = 0;
        push_ramp(1000, 1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #2;
            chk($sformatf("post_reset_valid_c%0d", c), int'(bus.o_valid), (c == 4) ? 1 : 0);
            if (c == 1)
                chk("post_reset_aw_idle", bus.o_aw, 0);
            if (c == 2)
                chk("post_reset_aw_track", bus.o_aw, -500);
        end
        chk("post_reset_cmd", bus.o_CMD, 100);
        chk("post_reset_pending_updates", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
